// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - single-register pipelined ALU with accumulator and ready/valid handshake
// Defining ALU_PIPE_FLAGS_EN adds registered out_zero and out_ovf outputs.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_valid,
    input  logic             out_ready
`ifdef ALU_PIPE_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_ovf
`endif
);

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_NOT = 3'b011,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101,
        OP_ACC = 3'b110,
        OP_CLR = 3'b111
    } op_e;

    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_valid;
    logic [WIDTH-1:0] r_acc;

    op_e              w_op;
    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_accsum;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;

    assign w_op     = op_e'(op);
    // One output register: a held result can be drained and replaced in the same cycle.
    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    assign w_sum    = {1'b0, a} + {1'b0, b};
    assign w_diff   = {1'b0, a} - {1'b0, b};
    assign w_accsum = {1'b0, r_acc} + {1'b0, a};

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        case (w_op)
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            OP_NOT: w_res = ~a;
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            OP_SUB: begin
                // Top bit of the widened difference is the unsigned borrow (a < b).
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
            end
            OP_ACC: begin
                w_res   = w_accsum[WIDTH-1:0];
                w_carry = w_accsum[WIDTH];
            end
            OP_CLR: w_res = '0;
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_acc    <= '0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_result <= w_res;
            r_carry  <= w_carry;
            if (w_op == OP_ACC || w_op == OP_CLR) begin
                r_acc <= w_res;
            end
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_result = r_result;
    assign out_carry  = r_carry;
    assign out_valid  = r_valid;

`ifdef ALU_PIPE_FLAGS_EN
    logic w_ovf;
    logic r_zero;
    logic r_ovf;

    // Signed overflow: operands of equal sign produce a result of the other sign.
    always_comb begin
        w_ovf = 1'b0;
        case (w_op)
            OP_ADD:  w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            OP_SUB:  w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            OP_ACC:  w_ovf = (r_acc[WIDTH-1] == a[WIDTH-1]) && (w_accsum[WIDTH-1] != r_acc[WIDTH-1]);
            default: w_ovf = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_zero <= (w_res == '0);
            r_ovf  <= w_ovf;
        end
    end

    assign out_zero = r_zero;
    assign out_ovf  = r_ovf;
`endif

endmodule
